decode_cycle: RTL
=================

// Module: decode_cycle
// PURPOSE
//  ID stage of the 5-stage RV32I pipeline; consumes the IF/ID outputs (InstrD, PCD, PCPlus4D).
//  Holds the 32x32 register file, main/ALU control decoder and immediate generator.
//  Registers all results into the ID/EX pipeline register for execute_cycle.
//  Takes the writeback port from WB and exposes source registers to the hazard unit.
// PARAMETERS
//  XLEN    32  datapath / register width
//  NREG    32  architectural registers (x0 hardwired zero)
// PORTS
//  clk         in   1     pipeline clock, all state updates on rising edge
//  rst         in   1     asynchronous, active-low reset
//  InstrD      in   32    instruction from IF/ID
//  PCD         in   32    PC of InstrD
//  PCPlus4D    in   32    PCD+4
//  RegWriteW   in   1     writeback enable
//  RDW         in   5     writeback destination
//  ResultW     in   32    writeback data
//  FlushE      in   1     hazard unit: load bubble into ID/EX on this edge
//  Rs1D,Rs2D   out  5     InstrD[19:15],[24:20], combinational, for hazard unit
//  RegWriteE   out  1     ID/EX: register write enable
//  ResultSrcE  out  2     00 ALU, 01 memory, 10 PC+4
//  MemWriteE   out  1     store enable
//  BranchE     out  1     beq
//  JumpE       out  1     jal
//  ALUSrcE     out  1     1 = ImmExtE as ALU operand B
//  ALUControlE out  3     000 add,001 sub,010 and,011 or,101 slt
//  RD1E,RD2E   out  32    register operands
//  ImmExtE     out  32    sign-extended immediate
//  Rs1E,Rs2E   out  5     source indices (forwarding)
//  RDE         out  5     InstrD[11:7]
//  PCE,PCPlus4E out 32    PC pass-through
// BEHAVIOUR
//  - rst low (async): all ID/EX outputs 0, all 32 registers 0; holds while low.
//  - Latency: 1 cycle InstrD -> *E outputs. No stall input; IF/ID stall is fetch-side.
//  - Regfile write at rising edge when RegWriteW && RDW!=0; writes to x0 dropped; x0 reads 0.
//  - Write-through bypass: same-cycle RegWriteW && RDW!=0 && RDW==rs -> RDn gets ResultW.
//  - Decode by opcode (RegW,ResultSrc,MemW,Br,Jmp,ALUSrc,ALUOp,ImmSrc):
//    0000011 lw  : 1,01,0,0,0,1,add,I    0100011 sw : 0,00,1,0,0,1,add,S
//    0110011 R   : 1,00,0,0,0,0,f3/f7,-  0010011 I  : 1,00,0,0,0,1,f3,I
//    1100011 beq : 0,00,0,1,0,0,sub,B    1101111 jal: 1,10,0,0,1,0,add,J
//    any other opcode: all control 0 (behaves as bubble), data fields still registered.
//  - ALU from funct3: 000 add (sub iff R-type && funct7[5]), 010 slt, 110 or, 111 and;
//    other funct3 -> add. funct7 ignored for op 0010011.
//  - Immediates sign-extended from bit 31: I[31:20]; S{[31:25],[11:7]};
//    B{[31],[7],[30:25],[11:8],0}; J{[31],[19:12],[20],[30:21],0}; none -> 0.
//  - FlushE=1 at edge: all ID/EX outputs load 0 (overrides decode); regfile write still occurs.
//  - rst asserted mid-pipeline: in-flight ID/EX contents and regfile lost, no partial write.
// TESTING
//  1 rst=0 200ns, drive garbage InstrD -> all *E outputs 0; release rst -> decode resumes next edge.
//  2 InstrD=0xFFF00093 (addi x1,x0,-1) -> next edge ImmExtE=0xFFFFFFFF, RDE=1, RegWriteE=1,
//    ALUSrcE=1, ALUControlE=000, RD1E=0.
//  3 InstrD=0x00528333 (add x6,x5,x5) with RegWriteW=1,RDW=5,ResultW=0x1234 same cycle ->
//    RD1E=RD2E=0x1234; next read of x5 also 0x1234.
//  4 RegWriteW=1,RDW=0,ResultW=0xDEAD then read x0 -> RD1E=0.
//  5 InstrD=0x0020A423 (sw x2,8(x1)) -> ImmExtE=8, MemWriteE=1, RegWriteE=0;
//    InstrD=0xFE208EE3 (beq x1,x2,-4) -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=001.
//  6 Any valid InstrD with FlushE=1 -> all *E outputs 0 next edge, while RDW write still lands.

Source files
------------

// File: rtl/decode_cycle.sv
// decode_cycle: ID stage of the 5-stage RV32I pipeline.
//
// Decodes InstrD (from IF/ID), reads the 32x32 register file, builds the
// sign-extended immediate and registers everything into the ID/EX
// pipeline register consumed by execute_cycle.
//
// Ports
//   clk, rst          pipeline clock; asynchronous active-low reset
//   InstrD/PCD/PCPlus4D  instruction and its PCs from IF/ID
//   RegWriteW/RDW/ResultW  writeback port from WB
//   FlushE            load a bubble into ID/EX on this edge
//   Rs1D/Rs2D         combinational source indices for the hazard unit
//   *E                registered ID/EX outputs (control, operands, immediate,
//                     register indices, PC pass-through)
module decode_cycle #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ALUSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RDE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_src_e;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } idex_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [4:0] rd_d;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7_5 = InstrD[30];
  assign rd_d     = InstrD[11:7];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  // ------------------------------------------------------------------
  // Register file
  // ------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NREG];
  logic            wb_en;

  assign wb_en = RegWriteW && (RDW != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q <= '{default: '0};
    end else if (wb_en) begin
      rf_q[RDW] <= ResultW;
    end
  end

  // x0 reads zero; a same-cycle writeback to the read index is bypassed
  // so the value reaches ID/EX without waiting for the array update.
  logic [XLEN-1:0] rd1_d, rd2_d;

  always_comb begin
    rd1_d = '0;
    if (Rs1D != 5'd0) begin
      if (wb_en && (RDW == Rs1D)) rd1_d = ResultW;
      else                        rd1_d = rf_q[Rs1D];
    end
  end

  always_comb begin
    rd2_d = '0;
    if (Rs2D != 5'd0) begin
      if (wb_en && (RDW == Rs2D)) rd2_d = ResultW;
      else                        rd2_d = rf_q[Rs2D];
    end
  end

  // ------------------------------------------------------------------
  // Main decoder
  // ------------------------------------------------------------------
  logic        reg_write_d;
  result_src_e result_src_d;
  logic        mem_write_d;
  logic        branch_d;
  logic        jump_d;
  logic        alu_src_d;
  alu_op_e     alu_op_d;
  imm_src_e    imm_src_d;

  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = RES_ALU;
    mem_write_d  = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    alu_src_d    = 1'b0;
    alu_op_d     = ALUOP_ADD;
    imm_src_d    = IMM_NONE;
    case (opcode)
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        result_src_d = RES_MEM;
        alu_src_d    = 1'b1;
        imm_src_d    = IMM_I;
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_src_d   = IMM_S;
      end
      OP_RTYPE: begin
        reg_write_d = 1'b1;
        alu_op_d    = ALUOP_FUNCT;
      end
      OP_ITYPE: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_op_d    = ALUOP_FUNCT;
        imm_src_d   = IMM_I;
      end
      OP_BRANCH: begin
        branch_d  = 1'b1;
        alu_op_d  = ALUOP_SUB;
        imm_src_d = IMM_B;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        result_src_d = RES_PC4;
        jump_d       = 1'b1;
        imm_src_d    = IMM_J;
      end
      default: ;  // unknown opcode decodes as a bubble
    endcase
  end

  // ------------------------------------------------------------------
  // ALU decoder
  // ------------------------------------------------------------------
  alu_ctrl_e alu_ctrl_d;

  always_comb begin
    alu_ctrl_d = ALU_ADD;
    case (alu_op_d)
      ALUOP_SUB: alu_ctrl_d = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: alu_ctrl_d = (opcode == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010: alu_ctrl_d = ALU_SLT;
          3'b110: alu_ctrl_d = ALU_OR;
          3'b111: alu_ctrl_d = ALU_AND;
          default: alu_ctrl_d = ALU_ADD;
        endcase
      end
      default: alu_ctrl_d = ALU_ADD;
    endcase
  end

  // ------------------------------------------------------------------
  // Immediate generator
  // ------------------------------------------------------------------
  logic [XLEN-1:0] imm_d;

  always_comb begin
    imm_d = '0;
    case (imm_src_d)
      IMM_I: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                      InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm_d = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                      InstrD[20], InstrD[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // ID/EX pipeline register
  // ------------------------------------------------------------------
  idex_t idex_d, idex_q;

  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.reg_write  = reg_write_d;
      idex_d.result_src = result_src_d;
      idex_d.mem_write  = mem_write_d;
      idex_d.branch     = branch_d;
      idex_d.jump       = jump_d;
      idex_d.alu_src    = alu_src_d;
      idex_d.alu_ctrl   = alu_ctrl_d;
      idex_d.rd1        = rd1_d;
      idex_d.rd2        = rd2_d;
      idex_d.imm        = imm_d;
      idex_d.rs1        = Rs1D;
      idex_d.rs2        = Rs2D;
      idex_d.rd         = rd_d;
      idex_d.pc         = PCD;
      idex_d.pc_plus4   = PCPlus4D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign ResultSrcE  = idex_q.result_src;
  assign MemWriteE   = idex_q.mem_write;
  assign BranchE     = idex_q.branch;
  assign JumpE       = idex_q.jump;
  assign ALUSrcE     = idex_q.alu_src;
  assign ALUControlE = idex_q.alu_ctrl;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RDE         = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;

endmodule
